prog_ctrl: RTL and testbench

PROG_CTRL -- requirements
Module: prog_ctrl

---
 rtl/prog_ctrl.sv | 119 +++++++++++
 tb/tb_prog_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/prog_ctrl.sv
// Program-run controller: IDLE -> LOAD -> RUN -> DONE sequencing of the program counter.
// Optional watchdog on RUN length is enabled by defining PROG_CTRL_WATCHDOG_EN.
module prog_ctrl #(
  parameter logic [9:0]  PROG0_BASE = 10'd0,
  parameter logic [9:0]  PROG1_BASE = 10'd256,
  parameter logic [9:0]  PROG2_BASE = 10'd512,
  parameter logic [15:0] MAX_CYCLES = 16'd50000
) (
  input  logic        CLK,
  input  logic        Init,
  input  logic        Start,
  input  logic [1:0]  ProgSel,
  input  logic        HaltInstr,
  output logic        PcLoad,
  output logic [9:0]  PcLoadVal,
  output logic        PcHold,
  output logic        Done,
  output logic        Timeout,
  output logic [15:0] CycleCnt,
  output logic [1:0]  dbg_state
);

  // Handshake: Start is a level request; a new run needs Start low then high after DONE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  sel_q;
  logic [15:0] cnt_q;
  logic [15:0] cnt_inc;
  logic        wd_hit;
  logic        run_exit;
  logic        start_run;

  assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign start_run = (state_q == IDLE) && Start;
  assign run_exit  = HaltInstr || wd_hit;

`ifdef PROG_CTRL_WATCHDOG_EN
  logic to_q;

  // Compared against the pre-increment count so the exit cycle reads exactly MAX_CYCLES.
  assign wd_hit = (state_q == RUN) && (cnt_q == MAX_CYCLES - 16'd1);

  always_ff @(posedge CLK) begin
    if (Init) begin
      to_q <= 1'b0;
    end else if (start_run) begin
      to_q <= 1'b0;
    end else if (wd_hit && !HaltInstr) begin
      to_q <= 1'b1;
    end
  end

  assign Timeout = to_q;
`else
  logic unused_max_cycles;

  assign unused_max_cycles = ^MAX_CYCLES;
  assign wd_hit            = 1'b0;
  assign Timeout           = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (Init) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      if (start_run) begin
        sel_q <= ProgSel;
        cnt_q <= 16'd0;
      end else if (state_q == RUN) begin
        cnt_q <= cnt_inc;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     if (run_exit) state_d = DONE;
      DONE:    if (!Start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    PcLoad    = 1'b0;
    PcLoadVal = 10'd0;
    PcHold    = 1'b1;
    Done      = 1'b0;
    case (state_q)
      LOAD: begin
        PcLoad = 1'b1;
        PcHold = 1'b0;
        case (sel_q)
          2'd0:    PcLoadVal = PROG0_BASE;
          2'd1:    PcLoadVal = PROG1_BASE;
          default: PcLoadVal = PROG2_BASE;
        endcase
      end
      RUN:     PcHold = 1'b0;
      DONE:    Done = 1'b1;
      default: ;
    endcase
  end

  assign CycleCnt  = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_prog_ctrl.sv
// Self-checking bench for prog_ctrl: vector table plus multi-cycle sequences,
// expected words queued at drive time and popped after each clock edge.
module tb_prog_ctrl;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic        CLK = 1'b0;
  logic        Init = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  ProgSel = 2'd0;
  logic        HaltInstr = 1'b0;
  logic        PcLoad;
  logic [9:0]  PcLoadVal;
  logic        PcHold;
  logic        Done;
  logic        Timeout;
  logic [15:0] CycleCnt;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        init;
    logic        start;
    logic [1:0]  sel;
    logic        halt;
    logic [1:0]  st;
    logic [9:0]  val;
    logic        to;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[13];

  prog_ctrl #(
    .PROG0_BASE(10'd0),
    .PROG1_BASE(10'd256),
    .PROG2_BASE(10'd512),
    .MAX_CYCLES(16'd8)
  ) dut (
    .CLK(CLK),
    .Init(Init),
    .Start(Start),
    .ProgSel(ProgSel),
    .HaltInstr(HaltInstr),
    .PcLoad(PcLoad),
    .PcLoadVal(PcLoadVal),
    .PcHold(PcHold),
    .Done(Done),
    .Timeout(Timeout),
    .CycleCnt(CycleCnt),
    .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  // Output word implied by a state: strobe only in LOAD, hold in IDLE/DONE, Done only in DONE.
  function automatic logic [31:0] exp_word(input logic [1:0] st, input logic [9:0] val,
                                           input logic to, input logic [15:0] cnt);
    logic ld, hold, dn;
    ld   = (st == S_LOAD);
    hold = (st == S_IDLE) || (st == S_DONE);
    dn   = (st == S_DONE);
    return {st, ld, (ld ? val : 10'd0), hold, dn, to, cnt};
  endfunction

  task automatic step(input logic i, input logic s, input logic [1:0] ps, input logic h,
                      input logic [31:0] e, input string name);
    logic [31:0] got, want;
    Init = i;
    Start = s;
    ProgSel = ps;
    HaltInstr = h;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    got  = {dbg_state, PcLoad, PcLoadVal, PcHold, Done, Timeout, CycleCnt};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got st=%0d ld=%0b val=%0d hold=%0b done=%0b to=%0b cnt=%0d, expected st=%0d ld=%0b val=%0d hold=%0b done=%0b to=%0b cnt=%0d",
               name, got[31:30], got[29], got[28:19], got[18], got[17], got[16], got[15:0],
               want[31:30], want[29], want[28:19], want[18], want[17], want[16], want[15:0]);
    end
  endtask

  initial begin
    // init, start, sel, halt -> state, load value, timeout, count
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, S_IDLE, 10'd0,   1'b0, 16'd0};
    vecs[1]  = '{1'b0, 1'b1, 2'd1, 1'b0, S_LOAD, 10'd256, 1'b0, 16'd0};
    vecs[2]  = '{1'b0, 1'b0, 2'd2, 1'b0, S_RUN,  10'd0,   1'b0, 16'd0};
    vecs[3]  = '{1'b0, 1'b0, 2'd2, 1'b0, S_RUN,  10'd0,   1'b0, 16'd1};
    vecs[4]  = '{1'b0, 1'b0, 2'd2, 1'b1, S_DONE, 10'd0,   1'b0, 16'd2};
    vecs[5]  = '{1'b0, 1'b0, 2'd2, 1'b0, S_IDLE, 10'd0,   1'b0, 16'd2};
    vecs[6]  = '{1'b0, 1'b1, 2'd0, 1'b0, S_LOAD, 10'd0,   1'b0, 16'd0};
    vecs[7]  = '{1'b0, 1'b1, 2'd3, 1'b0, S_RUN,  10'd0,   1'b0, 16'd0};
    vecs[8]  = '{1'b0, 1'b1, 2'd3, 1'b0, S_RUN,  10'd0,   1'b0, 16'd1};
    vecs[9]  = '{1'b0, 1'b0, 2'd1, 1'b0, S_RUN,  10'd0,   1'b0, 16'd2};
    vecs[10] = '{1'b0, 1'b1, 2'd1, 1'b0, S_RUN,  10'd0,   1'b0, 16'd3};
    vecs[11] = '{1'b0, 1'b1, 2'd1, 1'b0, S_RUN,  10'd0,   1'b0, 16'd4};
    vecs[12] = '{1'b0, 1'b1, 2'd1, 1'b1, S_DONE, 10'd0,   1'b0, 16'd5};

    #2;
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].init, vecs[i].start, vecs[i].sel, vecs[i].halt,
           exp_word(vecs[i].st, vecs[i].val, vecs[i].to, vecs[i].cnt), $sformatf("vec%0d", i));
    end

    // Start held high in DONE must not restart.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 2'd0, 1'b0, exp_word(S_DONE, 10'd0, 1'b0, 16'd5), "done_hold");
    end
    step(1'b0, 1'b0, 2'd0, 1'b0, exp_word(S_IDLE, 10'd0, 1'b0, 16'd5), "done_release");
    step(1'b0, 1'b1, 2'd3, 1'b0, exp_word(S_LOAD, 10'd512, 1'b0, 16'd0), "sel3_load");
    step(1'b0, 1'b0, 2'd0, 1'b0, exp_word(S_RUN, 10'd0, 1'b0, 16'd0), "sel3_run");
    step(1'b0, 1'b0, 2'd0, 1'b0, exp_word(S_RUN, 10'd0, 1'b0, 16'd1), "run_c1");
    step(1'b0, 1'b0, 2'd0, 1'b0, exp_word(S_RUN, 10'd0, 1'b0, 16'd2), "run_c2");
    // Init wins over Start and HaltInstr on the third RUN cycle.
    step(1'b1, 1'b1, 2'd2, 1'b1, exp_word(S_IDLE, 10'd0, 1'b0, 16'd0), "init_mid_run");
    step(1'b1, 1'b1, 2'd1, 1'b0, exp_word(S_IDLE, 10'd0, 1'b0, 16'd0), "init_over_start");
    step(1'b0, 1'b1, 2'd2, 1'b0, exp_word(S_LOAD, 10'd512, 1'b0, 16'd0), "post_init_load");
    step(1'b0, 1'b0, 2'd0, 1'b0, exp_word(S_RUN, 10'd0, 1'b0, 16'd0), "post_init_run");
    step(1'b0, 1'b0, 2'd0, 1'b1, exp_word(S_DONE, 10'd0, 1'b0, 16'd1), "post_init_halt");
    step(1'b0, 1'b0, 2'd0, 1'b0, exp_word(S_IDLE, 10'd0, 1'b0, 16'd1), "post_init_idle");

`ifdef PROG_CTRL_WATCHDOG_EN
    step(1'b0, 1'b1, 2'd0, 1'b0, exp_word(S_LOAD, 10'd0, 1'b0, 16'd0), "wd_load");
    step(1'b0, 1'b0, 2'd0, 1'b0, exp_word(S_RUN, 10'd0, 1'b0, 16'd0), "wd_run");
    for (int k = 1; k < 8; k++) begin
      step(1'b0, 1'b0, 2'd0, 1'b0, exp_word(S_RUN, 10'd0, 1'b0, 16'(k)), "wd_count");
    end
    step(1'b0, 1'b0, 2'd0, 1'b0, exp_word(S_DONE, 10'd0, 1'b1, 16'd8), "wd_fire");
    step(1'b0, 1'b0, 2'd0, 1'b0, exp_word(S_IDLE, 10'd0, 1'b1, 16'd8), "wd_retain");
    step(1'b0, 1'b1, 2'd1, 1'b0, exp_word(S_LOAD, 10'd256, 1'b0, 16'd0), "wd2_load");
    step(1'b0, 1'b0, 2'd0, 1'b0, exp_word(S_RUN, 10'd0, 1'b0, 16'd0), "wd2_run");
    for (int k = 1; k < 8; k++) begin
      step(1'b0, 1'b0, 2'd0, 1'b0, exp_word(S_RUN, 10'd0, 1'b0, 16'(k)), "wd2_count");
    end
    step(1'b0, 1'b0, 2'd0, 1'b1, exp_word(S_DONE, 10'd0, 1'b0, 16'd8), "wd2_halt_wins");
    step(1'b0, 1'b0, 2'd0, 1'b0, exp_word(S_IDLE, 10'd0, 1'b0, 16'd8), "wd2_idle");
`else
    step(1'b0, 1'b1, 2'd2, 1'b0, exp_word(S_LOAD, 10'd512, 1'b0, 16'd0), "sat_load");
    step(1'b0, 1'b0, 2'd0, 1'b0, exp_word(S_RUN, 10'd0, 1'b0, 16'd0), "sat_run");
    HaltInstr = 1'b0;
    repeat (69999) @(posedge CLK);
    #1;
    step(1'b0, 1'b0, 2'd0, 1'b0, exp_word(S_RUN, 10'd0, 1'b0, 16'hFFFF), "sat_70000");
    step(1'b0, 1'b0, 2'd0, 1'b1, exp_word(S_DONE, 10'd0, 1'b0, 16'hFFFF), "sat_halt");
    step(1'b0, 1'b0, 2'd0, 1'b0, exp_word(S_IDLE, 10'd0, 1'b0, 16'hFFFF), "sat_idle");
`endif

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
